iir_2slow_demux: RTL and testbench

IIR_2SLOW_DEMUX -- requirements
Module: iir_2slow_demux

---
 rtl/iir_pkg.sv | 16 +
 rtl/iir_2slow_demux.sv | 108 ++++++++++
 tb/tb_iir_2slow_demux.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/iir_pkg.sv
`default_nettype none
// ============================================================================
// iir_pkg -- shared types and constants for the 2-slow IIR demultiplexer
// Rev 1.0
// ============================================================================
package iir_pkg;

    localparam int IIR_WIDTH_DEFAULT = 8;

    typedef enum logic [0:0] {
        P_CH1 = 1'b0,
        P_CH2 = 1'b1
    } phase_e;

endpackage : iir_pkg
`default_nettype wire

// File: rtl/iir_2slow_demux.sv
`default_nettype none
// ============================================================================
// iir_2slow_demux -- splits an interleaved 2-slow stream into (y1, y2) pairs
// Rev 1.0
// ============================================================================
module iir_2slow_demux
    import iir_pkg::*;
#(
    parameter int WIDTH     = IIR_WIDTH_DEFAULT,
    parameter bit SOF_CHECK = 1'b1
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [WIDTH-1:0] y_in,
    input  logic             in_valid,
    input  logic             in_sof,
    output logic             in_ready,
    output logic [WIDTH-1:0] y1,
    output logic [WIDTH-1:0] y2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             align_err
);

    phase_e             r_phase;
    phase_e             w_phase_nxt;
    logic [WIDTH-1:0]   r_hold;
    logic [WIDTH-1:0]   r_y1;
    logic [WIDTH-1:0]   r_y2;
    logic               r_out_valid;
    logic               r_align_err;

    logic               w_in_ready;
    logic               w_in_xfer;
    logic               w_out_xfer;
    logic               w_realign;
    logic               w_hold_load;
    logic               w_pair_load;
    logic               w_out_valid_nxt;

    // A channel-1 sample only fills the hold register, so it never waits on downstream.
    assign w_in_ready = (r_phase == P_CH1) || !r_out_valid || out_ready;
    assign w_in_xfer  = in_valid && w_in_ready;
    assign w_out_xfer = r_out_valid && out_ready;

    always_comb begin
        w_phase_nxt     = r_phase;
        w_realign       = 1'b0;
        w_hold_load     = 1'b0;
        w_pair_load     = 1'b0;
        w_out_valid_nxt = r_out_valid;

        if (w_out_xfer) begin
            w_out_valid_nxt = 1'b0;
        end

        if (w_in_xfer) begin
            case (r_phase)
                P_CH1: begin
                    w_hold_load = 1'b1;
                    w_phase_nxt = P_CH2;
                end
                P_CH2: begin
                    if (SOF_CHECK && in_sof) begin
                        // Sample is really channel 1: restart collection, stay in P_CH2.
                        w_realign   = 1'b1;
                        w_hold_load = 1'b1;
                    end else begin
                        w_pair_load     = 1'b1;
                        w_out_valid_nxt = 1'b1;
                        w_phase_nxt     = P_CH1;
                    end
                end
                default: w_phase_nxt = P_CH1;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_phase     <= P_CH1;
            r_hold      <= '0;
            r_y1        <= '0;
            r_y2        <= '0;
            r_out_valid <= 1'b0;
            r_align_err <= 1'b0;
        end else begin
            r_phase     <= w_phase_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_align_err <= w_realign;
            if (w_hold_load) begin
                r_hold <= y_in;
            end
            if (w_pair_load) begin
                r_y1 <= r_hold;
                r_y2 <= y_in;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign y1        = r_y1;
    assign y2        = r_y2;
    assign out_valid = r_out_valid;
    assign align_err = r_align_err;

endmodule : iir_2slow_demux
`default_nettype wire

// File: tb/tb_iir_2slow_demux.sv
`default_nettype none
// ============================================================================
// tb_iir_2slow_demux -- directed vector bench for iir_2slow_demux
// Rev 1.0
// ============================================================================
module tb_iir_2slow_demux;

    typedef struct {
        string      tag;
        logic       v;
        logic       sof;
        logic [7:0] y;
        logic       ordy;
        logic       e_ir;
        logic       e_ov;
        logic [7:0] e_y1;
        logic [7:0] e_y2;
        logic       e_ae;
    } vec_t;

    logic       Clk = 1'b0;
    logic       Rst = 1'b0;
    logic [7:0] y_in = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_sof = 1'b0;
    logic       in_ready;
    logic [7:0] y1;
    logic [7:0] y2;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       align_err;

    int errors = 0;
    int checks = 0;

    vec_t vecs[$];

    always #5 Clk = ~Clk;

    iir_2slow_demux #(.WIDTH(8), .SOF_CHECK(1'b1)) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .y_in      (y_in),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .in_ready  (in_ready),
        .y1        (y1),
        .y2        (y2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .align_err (align_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string tag, input logic v, input logic sof,
                                input logic [7:0] y, input logic ordy, input logic e_ir,
                                input logic e_ov, input logic [7:0] e_y1,
                                input logic [7:0] e_y2, input logic e_ae);
        vec_t r;
        r.tag = tag; r.v = v; r.sof = sof; r.y = y; r.ordy = ordy;
        r.e_ir = e_ir; r.e_ov = e_ov; r.e_y1 = e_y1; r.e_y2 = e_y2; r.e_ae = e_ae;
        return r;
    endfunction

    // Drive on the falling edge, check in_ready before the rising edge, registers after it.
    task automatic apply(input vec_t t);
        @(negedge Clk);
        in_valid  = t.v;
        in_sof    = t.sof;
        y_in      = t.y;
        out_ready = t.ordy;
        #1;
        check({t.tag, ".in_ready"}, {31'd0, in_ready}, {31'd0, t.e_ir});
        @(posedge Clk);
        #1;
        check({t.tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, t.e_ov});
        check({t.tag, ".y1"},        {24'd0, y1},        {24'd0, t.e_y1});
        check({t.tag, ".y2"},        {24'd0, y2},        {24'd0, t.e_y2});
        check({t.tag, ".align_err"}, {31'd0, align_err}, {31'd0, t.e_ae});
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".out_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, ".y1"},        {24'd0, y1},        32'd0);
        check({tag, ".y2"},        {24'd0, y2},        32'd0);
        check({tag, ".align_err"}, {31'd0, align_err}, 32'd0);
        check({tag, ".in_ready"},  {31'd0, in_ready},  32'd1);
    endtask

    initial begin
        //                 tag     v  sof  y      ordy ir ov  y1     y2     ae
        // basic pair, one-cycle latency
        vecs.push_back(mk("s1a",  1, 1, 8'h08, 1, 1, 0, 8'h00, 8'h00, 0));
        vecs.push_back(mk("s1b",  1, 0, 8'h10, 1, 1, 1, 8'h08, 8'h10, 0));
        vecs.push_back(mk("s1c",  0, 0, 8'h00, 1, 1, 0, 8'h08, 8'h10, 0));
        // back-to-back stream, full throughput
        vecs.push_back(mk("s2a",  1, 1, 8'h0C, 1, 1, 0, 8'h08, 8'h10, 0));
        vecs.push_back(mk("s2b",  1, 0, 8'h08, 1, 1, 1, 8'h0C, 8'h08, 0));
        vecs.push_back(mk("s2c",  1, 1, 8'h08, 1, 1, 0, 8'h0C, 8'h08, 0));
        vecs.push_back(mk("s2d",  1, 0, 8'h10, 1, 1, 1, 8'h08, 8'h10, 0));
        vecs.push_back(mk("s2e",  1, 1, 8'h10, 1, 1, 0, 8'h08, 8'h10, 0));
        vecs.push_back(mk("s2f",  1, 0, 8'h04, 1, 1, 1, 8'h10, 8'h04, 0));
        // backpressure: channel 1 accepted, channel 2 stalled
        vecs.push_back(mk("s3a",  0, 0, 8'h00, 0, 1, 1, 8'h10, 8'h04, 0));
        vecs.push_back(mk("s3b",  1, 1, 8'h04, 0, 1, 1, 8'h10, 8'h04, 0));
        vecs.push_back(mk("s3c",  1, 0, 8'h20, 0, 0, 1, 8'h10, 8'h04, 0));
        vecs.push_back(mk("s3d",  1, 0, 8'h20, 0, 0, 1, 8'h10, 8'h04, 0));
        vecs.push_back(mk("s3e",  1, 0, 8'h20, 1, 1, 1, 8'h04, 8'h20, 0));
        vecs.push_back(mk("s3f",  0, 0, 8'h00, 1, 1, 0, 8'h04, 8'h20, 0));
        // sof in channel-2 slot realigns
        vecs.push_back(mk("s4a",  1, 1, 8'h08, 1, 1, 0, 8'h04, 8'h20, 0));
        vecs.push_back(mk("s4b",  1, 1, 8'h10, 1, 1, 0, 8'h04, 8'h20, 1));
        vecs.push_back(mk("s4c",  1, 0, 8'h20, 1, 1, 1, 8'h10, 8'h20, 0));
        vecs.push_back(mk("s4d",  0, 0, 8'h00, 1, 1, 0, 8'h10, 8'h20, 0));
        // invalid cycle between the two samples
        vecs.push_back(mk("s6a",  1, 1, 8'h08, 1, 1, 0, 8'h10, 8'h20, 0));
        vecs.push_back(mk("s6b",  0, 1, 8'hFF, 1, 1, 0, 8'h10, 8'h20, 0));
        vecs.push_back(mk("s6c",  1, 0, 8'h10, 1, 1, 1, 8'h08, 8'h10, 0));

        // reset state
        Rst = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        check_reset_outputs("rst0");
        @(negedge Clk);
        Rst = 1'b1;
        #1;
        check("rst0.in_ready_after_release", {31'd0, in_ready}, 32'd1);

        foreach (vecs[i]) apply(vecs[i]);

        // mid-operation reset with a pending pair and a half-collected pair
        apply(mk("s5a", 1, 1, 8'h08, 0, 1, 1, 8'h08, 8'h10, 0));
        @(negedge Clk);
        in_valid = 1'b0;
        Rst      = 1'b0;
        #1;
        check_reset_outputs("s5rst");
        @(negedge Clk);
        Rst = 1'b1;
        #1;
        check("s5rel.in_ready", {31'd0, in_ready}, 32'd1);
        apply(mk("s5b", 1, 1, 8'h04, 1, 1, 0, 8'h00, 8'h00, 0));
        apply(mk("s5c", 1, 0, 8'h20, 1, 1, 1, 8'h04, 8'h20, 0));
        apply(mk("s5d", 0, 0, 8'h00, 1, 1, 0, 8'h04, 8'h20, 0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_iir_2slow_demux
`default_nettype wire
